// File: rtl/rsa_pkg.sv
// Shared RSA constants and FSM encoding, used by the decrypt stage and the key generator.
package rsa_pkg;
  localparam int INPUTSIZE_DEF = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SQR  = 2'd2,
    DONE = 2'd3
  } rsa_state_e;
endpackage

// File: rtl/mod_mult.sv
// Combinational (a*b) mod n at full 2W product width; n=0 yields 0.
module mod_mult #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic [W-1:0] p
);
  logic [2*W-1:0] prod;

  always_comb begin
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    // Remainder is below n, so the narrowing cast loses nothing.
    p = (n == '0) ? '0 : W'(prod % {{W{1'b0}}, n});
  end
endmodule

// File: rtl/mod_exp_decrypt.sv
// Constant-time square-and-multiply c^d mod n (W iterations, 2 cycles each).
// Optional macro MOD_EXP_RANGE_CHECK_EN adds err for n<2 or c>=n.
import rsa_pkg::*;

module mod_exp_decrypt #(
  parameter int INPUTSIZE = INPUTSIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [INPUTSIZE-1:0] c,
  input  logic [INPUTSIZE-1:0] d,
  input  logic [INPUTSIZE-1:0] n,
  output logic                 busy,
  output logic                 done,
  output logic [INPUTSIZE-1:0] m
`ifdef MOD_EXP_RANGE_CHECK_EN
  ,output logic                err
`endif
);
  localparam int W  = INPUTSIZE;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  rsa_state_e    state_q, state_d;
  logic [W-1:0]  exp_q, mod_q, base_q, res_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  mm_a, mm_b, mm_n, mm_p;

  mod_mult #(.W(W)) u_mm (.a(mm_a), .b(mm_b), .n(mm_n), .p(mm_p));

  // Single multiplier: capture reduces c (c*1 mod n), MUL and SQR use the captured modulus.
  always_comb begin
    state_d = state_q;
    mm_a    = c;
    mm_b    = W'(1);
    mm_n    = n;
    case (state_q)
      IDLE: if (start) state_d = MUL;
      MUL: begin
        mm_a    = res_q;
        mm_b    = base_q;
        mm_n    = mod_q;
        state_d = SQR;
      end
      SQR: begin
        mm_a    = base_q;
        mm_b    = base_q;
        mm_n    = mod_q;
        state_d = (cnt_q < LAST) ? MUL : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      exp_q   <= '0;
      mod_q   <= '0;
      base_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      m       <= '0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          exp_q  <= d;
          mod_q  <= n;
          base_q <= mm_p;
          res_q  <= (n > W'(1)) ? W'(1) : '0;
          cnt_q  <= '0;
          busy   <= 1'b1;
        end
        MUL: if (exp_q[0]) res_q <= mm_p;
        SQR: begin
          base_q <= mm_p;
          exp_q  <= exp_q >> 1;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            m    <= res_q;
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MOD_EXP_RANGE_CHECK_EN
  logic bad_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bad_q <= 1'b0;
      err   <= 1'b0;
    end else if (state_q == IDLE && start) begin
      bad_q <= (n < W'(2)) || (c >= n);
      err   <= 1'b0;
    end else if (state_q == SQR && cnt_q == LAST) begin
      err   <= bad_q;
    end
  end
`endif
endmodule
